mem_io_ctrl: RTL and testbench
==============================

// Module: mem_io_ctrl
// PURPOSE
//  Memory/IO controller directly downstream of the lab8 CPU memory port. Decodes CPU
//  mem_cmd/mem_addr and routes each access to the 256x16 synchronous RAM, the LED
//  register, the HEX value register or the switch port, returning read data with a
//  single-cycle mem_ready handshake. It replaces ad-hoc tri-state/compare glue in lab8_top.
// PARAMETERS
//  ADDR_W   9         CPU address width
//  DATA_W   16        data width
//  RAM_AW   8         RAM address width; RAM occupies 0x000..(2^RAM_AW - 1)
//  LED_W    8         LED register width
//  SW_W     8         switch port width
// PORTS
//  clk         in   1        single clock, all state on posedge
//  reset       in   1        synchronous, active-high
//  mem_cmd     in   2        MNONE/MREAD/MWRITE (package enum)
//  mem_addr    in   ADDR_W   CPU byte-free word address
//  write_data  in   DATA_W   CPU write data
//  read_data   out  DATA_W   registered read data, valid when mem_ready=1 on a read
//  mem_ready   out  1        1-cycle pulse: access complete
//  ram_addr    out  RAM_AW   to RAM
//  ram_we      out  1        RAM write enable
//  ram_wdata   out  DATA_W   to RAM
//  ram_rdata   in   DATA_W   from RAM, valid 1 cycle after ram_addr sampled
//  sw_in       in   SW_W     raw asynchronous switches
//  led_out     out  LED_W    LED register
//  hex_value   out  DATA_W   HEX register (to 7-seg decoders)
//  bad_addr    out  1        sticky: access to unmapped address
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; read_data=0, mem_ready=0, ram_we=0, led_out=0,
//   hex_value=0, bad_addr=0, sync flops=0. Reset asserted mid-access aborts it: no
//   mem_ready, no RAM write issued that cycle.
//  Map: 0x000-0x0FF RAM | 0x100 LED (W; R returns zero-extended led_out) |
//   0x120 HEX (R/W) | 0x140 SW (R only; W ignored, not an error) | else unmapped.
//  FSM IDLE -> accept when mem_cmd!=MNONE. Commands are sampled only in IDLE.
//   RAM write: ram_we=1 combinationally in IDLE cycle; -> RESP; mem_ready=1 next cycle.
//   RAM read: ram_addr driven in IDLE cycle -> RD_WAIT -> read_data<=ram_rdata -> RESP.
//    Latency: mem_ready 2 cycles after acceptance.
//   Reg write (LED/HEX): register updates at accept edge; -> RESP (latency 1).
//   Reg/SW read: read_data<=value at accept edge; -> RESP (latency 1).
//   Unmapped: bad_addr<=1, write dropped, read_data<=0; completes with latency 1.
//  RESP: mem_ready=1 for exactly one cycle, then IDLE. A command still held in the IDLE
//   cycle after RESP is a new access (CPU drops/changes mem_cmd on mem_ready).
//  Width: LED write takes write_data[LED_W-1:0]; SW read zero-extends; ram_addr =
//   mem_addr[RAM_AW-1:0] latched at accept and held through RD_WAIT.
//  Switches: 2-flop synchronizer; SW read returns 2nd-stage value (2-cycle lag).
//  read_data holds last value between accesses; unchanged by writes.
//  mem_cmd encoding 2'b11 treated as MNONE (ignored, no error).
// STRUCTURE
//  Package lab8_io_pkg: typedef enum logic[1:0] {MNONE,MREAD,MWRITE} mem_cmd_t;
//   localparams ADDR_LED=9'h100, ADDR_HEX=9'h120, ADDR_SW=9'h140; FSM state enum
//   {IDLE,RD_WAIT,RESP}.
//  Sub-module sync2 (parameterized width, 2-flop synchronizer with sync reset) for sw_in.
//  Remaining logic (decode, FSM, registers) flat in mem_io_ctrl.
// TESTING (clk period 10; model RAM as 1-cycle sync-read behavioural array)
//  1 reset=1 two cycles -> all outputs 0, state IDLE; mem_cmd=MREAD held in reset -> no mem_ready.
//  2 MWRITE 0x005 data 16'hABCD, then MREAD 0x005 -> ram_we pulses once; read mem_ready
//    2 cycles after accept, read_data=16'hABCD.
//  3 MWRITE 0x100 data 16'h01A5 -> led_out=8'hA5 after accept edge, mem_ready next cycle;
//    MREAD 0x100 -> read_data=16'h00A5.
//  4 sw_in=8'h3C, wait 3 cycles, MREAD 0x140 -> read_data=16'h003C; MWRITE 0x140 ->
//    no change anywhere, bad_addr=0.
//  5 MREAD 0x1FF -> read_data=0, bad_addr=1 sticky through later valid accesses until reset.
//  6 MREAD 0x010 accepted, reset asserted in RD_WAIT -> no mem_ready, read_data=0, IDLE.

Source files
------------

// File: rtl/lab8_io_pkg.sv
// Shared types and address map for the lab8 memory/IO controller.
//   mem_cmd_t : CPU memory command encoding (2'b11 is unused and ignored)
//   state_t   : controller FSM states
//   target_t  : decoded destination of an access
//   ADDR_*    : word addresses of the memory-mapped registers
package lab8_io_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_LED,
    TGT_HEX,
    TGT_SW,
    TGT_BAD
  } target_t;

  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_HEX = 9'h120;
  localparam logic [8:0] ADDR_SW  = 9'h140;

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchronizer for slow asynchronous inputs (the board switches).
//   clk   : destination clock
//   reset : synchronous, active-high; clears both stages
//   d     : asynchronous input bus
//   q     : synchronized output, two clk cycles behind d
module sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make meta and q sample together at the edge,
  // so q gets the old meta; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller behind the lab8 CPU memory port. Decodes each CPU access
// and routes it to the external 256x16 synchronous RAM, the LED register, the
// HEX register or the switch port, completing with a one-cycle mem_ready pulse.
//   clk, reset          : clock; synchronous active-high reset
//   mem_cmd             : MNONE/MREAD/MWRITE, sampled only in IDLE
//   mem_addr/write_data : CPU address and write data
//   read_data           : registered read result, holds between accesses
//   mem_ready           : one-cycle completion pulse
//   ram_addr/ram_we/ram_wdata/ram_rdata : synchronous RAM port (1-cycle read)
//   sw_in               : raw switches, synchronized internally
//   led_out, hex_value  : output registers
//   bad_addr            : sticky flag, set by any access to an unmapped address
module mem_io_ctrl
  import lab8_io_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RAM_AW = 8,
  parameter int LED_W  = 8,
  parameter int SW_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic [DATA_W-1:0] hex_value,
  output logic              bad_addr
);

  state_t              state, state_next;
  target_t             target;
  logic                is_read, is_write;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [SW_W-1:0]     sw_sync;

  // Datapath controls produced by the FSM and applied in the register block.
  logic                rd_load;
  logic [DATA_W-1:0]   rd_value;
  logic                led_load, hex_load, bad_set, addr_load;

  sync2 #(.WIDTH(SW_W)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sw_sync)
  );

  // 2'b11 matches neither command and is therefore ignored like MNONE.
  assign is_read   = (mem_cmd == MREAD);
  assign is_write  = (mem_cmd == MWRITE);
  assign ram_wdata = write_data;

  always_comb begin
    if (mem_addr[ADDR_W-1:RAM_AW] == '0)         target = TGT_RAM;
    else if (mem_addr == ADDR_W'(ADDR_LED))      target = TGT_LED;
    else if (mem_addr == ADDR_W'(ADDR_HEX))      target = TGT_HEX;
    else if (mem_addr == ADDR_W'(ADDR_SW))       target = TGT_SW;
    else                                         target = TGT_BAD;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_addr   = ram_addr_q;
    mem_ready  = 1'b0;
    rd_load    = 1'b0;
    rd_value   = '0;
    led_load   = 1'b0;
    hex_load   = 1'b0;
    bad_set    = 1'b0;
    addr_load  = 1'b0;

    unique case (state)
      IDLE: begin
        // RAM sees the CPU address directly so its read starts at the accept edge.
        ram_addr = mem_addr[RAM_AW-1:0];
        if (is_read || is_write) begin
          addr_load  = 1'b1;
          state_next = RESP;
          unique case (target)
            TGT_RAM: begin
              if (is_write) ram_we     = 1'b1;
              else          state_next = RD_WAIT;
            end
            TGT_LED: begin
              if (is_write) led_load = 1'b1;
              else begin
                rd_load  = 1'b1;
                rd_value = DATA_W'(led_out);
              end
            end
            TGT_HEX: begin
              if (is_write) hex_load = 1'b1;
              else begin
                rd_load  = 1'b1;
                rd_value = hex_value;
              end
            end
            TGT_SW: begin
              // Writes to the switch port complete normally and change nothing.
              if (is_read) begin
                rd_load  = 1'b1;
                rd_value = DATA_W'(sw_sync);
              end
            end
            default: begin
              bad_set = 1'b1;
              rd_load = is_read;
            end
          endcase
        end
      end
      RD_WAIT: begin
        rd_load    = 1'b1;
        rd_value   = ram_rdata;
        state_next = RESP;
      end
      RESP: begin
        mem_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A reset cycle aborts whatever is in flight: no completion, no RAM write.
    if (reset) begin
      ram_we    = 1'b0;
      mem_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      led_out    <= '0;
      hex_value  <= '0;
      bad_addr   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      if (rd_load)   read_data  <= rd_value;
      if (led_load)  led_out    <= write_data[LED_W-1:0];
      if (hex_load)  hex_value  <= write_data;
      if (bad_set)   bad_addr   <= 1'b1;
      if (addr_load) ram_addr_q <= mem_addr[RAM_AW-1:0];
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed scenarios followed by a random
// access stream checked against a behavioural model of the address map.
module tb_mem_io_ctrl;
  import lab8_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic [15:0] hex_value;
  logic        bad_addr;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_count     = 0;

  // Behavioural RAM seen by the DUT, and the model's own view of expected state.
  logic [15:0] ram_arr [256];
  logic [15:0] ref_mem [256];
  logic [7:0]  exp_led, exp_sw;
  logic [15:0] exp_hex, exp_rd;
  logic        exp_bad;

  always #5 clk = ~clk;

  mem_io_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .hex_value  (hex_value),
    .bad_addr   (bad_addr)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      ram_arr[ram_addr] <= ram_wdata;
      we_count++;
    end
    ram_rdata <= ram_arr[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Model: applies one access to the expected state and returns the expected
  // latency from accept edge to mem_ready (0 means no access takes place).
  task automatic model_access(input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [15:0] wdata, output int lat);
    lat = 0;
    if (cmd == 2'b01 || cmd == 2'b10) begin
      lat = 1;
      if (addr < 9'h100) begin
        if (cmd == 2'b10) ref_mem[addr[7:0]] = wdata;
        else begin
          exp_rd = ref_mem[addr[7:0]];
          lat    = 2;
        end
      end else if (addr == 9'h100) begin
        if (cmd == 2'b10) exp_led = wdata[7:0];
        else              exp_rd  = {8'h00, exp_led};
      end else if (addr == 9'h120) begin
        if (cmd == 2'b10) exp_hex = wdata;
        else              exp_rd  = exp_hex;
      end else if (addr == 9'h140) begin
        if (cmd == 2'b01) exp_rd = {8'h00, exp_sw};
      end else begin
        exp_bad = 1'b1;
        if (cmd == 2'b01) exp_rd = 16'h0000;
      end
    end
  endtask

  task automatic model_reset();
    exp_led = 8'h00;
    exp_hex = 16'h0000;
    exp_rd  = 16'h0000;
    exp_bad = 1'b0;
  endtask

  // Presents one command for one cycle, then measures cycles until mem_ready
  // (lat=0 if none within the bound) and whether mem_ready is still high after.
  task automatic do_access(input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wdata, output int lat,
                           output logic [15:0] rd, output logic ready_after);
    @(negedge clk);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wdata;
    @(posedge clk); #1;
    mem_cmd = MNONE;
    lat     = 0;
    for (int i = 1; i <= 8; i++) begin
      if (mem_ready === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    rd = read_data;
    @(posedge clk); #1;
    ready_after = mem_ready;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    mem_cmd    = MWRITE;
    mem_addr   = 9'h005;
    write_data = 16'hFFFF;
    sw_in      = 8'h00;
    repeat (2) begin
      @(posedge clk); #1;
      tests_run++;
      if ({mem_ready, ram_we, bad_addr, led_out, hex_value, read_data} !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: rdy=%b we=%b bad=%b led=%h hex=%h rd=%h, all zero required",
                 mem_ready, ram_we, bad_addr, led_out, hex_value, read_data);
      end
    end
    @(negedge clk);
    mem_cmd = MREAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (mem_ready !== 1'b0 || we_count != 0) begin
      tests_failed++;
      $display("FAIL reset_held_cmd: mem_ready=%b we_count=%0d, required 0 and 0", mem_ready, we_count);
    end
    @(negedge clk);
    reset   = 1'b0;
    mem_cmd = MNONE;
    model_reset();
  endtask

  task automatic test_ram();
    int lat, exp_lat, we0;
    logic [15:0] rd;
    logic ra;
    we0 = we_count;
    model_access(MWRITE, 9'h005, 16'hABCD, exp_lat);
    do_access(MWRITE, 9'h005, 16'hABCD, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || ra !== 1'b0 || we_count - we0 != 1 || rd !== exp_rd) begin
      tests_failed++;
      $display("FAIL ram_write: lat=%0d after=%b we_pulses=%0d rd=%h, required 1 0 1 %h",
               lat, ra, we_count - we0, rd, exp_rd);
    end
    we0 = we_count;
    model_access(MREAD, 9'h005, 16'h0000, exp_lat);
    do_access(MREAD, 9'h005, 16'h0000, lat, rd, ra);
    tests_run++;
    if (lat !== 2 || ra !== 1'b0 || we_count != we0 || rd !== 16'hABCD) begin
      tests_failed++;
      $display("FAIL ram_read: lat=%0d after=%b we_pulses=%0d rd=%h, required 2 0 0 abcd",
               lat, ra, we_count - we0, rd);
    end
  endtask

  task automatic test_regs();
    int lat, exp_lat;
    logic [15:0] rd;
    logic ra;
    model_access(MWRITE, 9'h100, 16'h01A5, exp_lat);
    do_access(MWRITE, 9'h100, 16'h01A5, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || led_out !== 8'hA5) begin
      tests_failed++;
      $display("FAIL led_write: lat=%0d led=%h, required 1 a5", lat, led_out);
    end
    model_access(MREAD, 9'h100, 16'h0000, exp_lat);
    do_access(MREAD, 9'h100, 16'h0000, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || rd !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL led_read: lat=%0d rd=%h, required 1 00a5", lat, rd);
    end
    model_access(MWRITE, 9'h120, 16'hBEEF, exp_lat);
    do_access(MWRITE, 9'h120, 16'hBEEF, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || hex_value !== 16'hBEEF || rd !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL hex_write: lat=%0d hex=%h rd=%h, required 1 beef 00a5", lat, hex_value, rd);
    end
    model_access(MREAD, 9'h120, 16'h0000, exp_lat);
    do_access(MREAD, 9'h120, 16'h0000, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || rd !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL hex_read: lat=%0d rd=%h, required 1 beef", lat, rd);
    end
  endtask

  task automatic test_switches();
    int lat, exp_lat;
    logic [15:0] rd;
    logic ra;
    sw_in  = 8'h3C;
    exp_sw = 8'h3C;
    repeat (3) @(posedge clk);
    model_access(MREAD, 9'h140, 16'h0000, exp_lat);
    do_access(MREAD, 9'h140, 16'h0000, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || rd !== 16'h003C) begin
      tests_failed++;
      $display("FAIL sw_read: lat=%0d rd=%h, required 1 003c", lat, rd);
    end
    // A change just before the accept edge has not yet crossed the synchronizer.
    sw_in = 8'hC3;
    do_access(MREAD, 9'h140, 16'h0000, lat, rd, ra);
    tests_run++;
    if (rd !== 16'h003C) begin
      tests_failed++;
      $display("FAIL sw_lag: rd=%h, required 003c", rd);
    end
    exp_sw = 8'hC3;
    repeat (3) @(posedge clk);
    model_access(MREAD, 9'h140, 16'h0000, exp_lat);
    do_access(MREAD, 9'h140, 16'h0000, lat, rd, ra);
    tests_run++;
    if (rd !== 16'h00C3) begin
      tests_failed++;
      $display("FAIL sw_read_new: rd=%h, required 00c3", rd);
    end
    model_access(MWRITE, 9'h140, 16'hFFFF, exp_lat);
    do_access(MWRITE, 9'h140, 16'hFFFF, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || rd !== 16'h00C3 || led_out !== 8'hA5 || hex_value !== 16'hBEEF || bad_addr !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_write: lat=%0d rd=%h led=%h hex=%h bad=%b, required 1 00c3 a5 beef 0",
               lat, rd, led_out, hex_value, bad_addr);
    end
  endtask

  task automatic test_unmapped();
    int lat, exp_lat;
    logic [15:0] rd;
    logic ra;
    model_access(MREAD, 9'h1FF, 16'h0000, exp_lat);
    do_access(MREAD, 9'h1FF, 16'h0000, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || rd !== 16'h0000 || bad_addr !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmapped_read: lat=%0d rd=%h bad=%b, required 1 0000 1", lat, rd, bad_addr);
    end
    model_access(MWRITE, 9'h180, 16'h1234, exp_lat);
    do_access(MWRITE, 9'h180, 16'h1234, lat, rd, ra);
    tests_run++;
    if (lat !== 1 || led_out !== 8'hA5 || hex_value !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL unmapped_write: lat=%0d led=%h hex=%h, required 1 a5 beef", lat, led_out, hex_value);
    end
    model_access(MREAD, 9'h005, 16'h0000, exp_lat);
    do_access(MREAD, 9'h005, 16'h0000, lat, rd, ra);
    tests_run++;
    if (rd !== 16'hABCD || bad_addr !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_sticky: rd=%h bad=%b, required abcd 1", rd, bad_addr);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    tests_run++;
    if (bad_addr !== 1'b0 || led_out !== 8'h00 || hex_value !== 16'h0000) begin
      tests_failed++;
      $display("FAIL bad_cleared: bad=%b led=%h hex=%h, required 0 00 0000", bad_addr, led_out, hex_value);
    end
  endtask

  task automatic test_reset_abort();
    int lat, exp_lat;
    logic [15:0] rd;
    logic ra;
    bit seen_ready;
    model_access(MREAD, 9'h005, 16'h0000, exp_lat);
    do_access(MREAD, 9'h005, 16'h0000, lat, rd, ra);
    @(negedge clk);
    mem_cmd  = MREAD;
    mem_addr = 9'h010;
    @(posedge clk); #1;
    mem_cmd = MNONE;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (mem_ready !== 1'b0 || read_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL abort_reset: mem_ready=%b rd=%h, required 0 0000", mem_ready, read_data);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) seen_ready = 1'b1;
    end
    tests_run++;
    if (seen_ready) begin
      tests_failed++;
      $display("FAIL abort_no_ready: mem_ready=1 seen after abort, required none");
    end
    model_access(MREAD, 9'h005, 16'h0000, exp_lat);
    do_access(MREAD, 9'h005, 16'h0000, lat, rd, ra);
    tests_run++;
    if (lat !== 2 || rd !== 16'hABCD) begin
      tests_failed++;
      $display("FAIL abort_recover: lat=%0d rd=%h, required 2 abcd", lat, rd);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat, r, sel;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata, rd;
    logic ra;
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 0) begin
        sw_in  = 8'($urandom);
        exp_sw = sw_in;
        repeat (3) @(posedge clk);
      end
      r = $urandom_range(0, 9);
      if (r < 4)       cmd = MREAD;
      else if (r < 8)  cmd = MWRITE;
      else if (r == 8) cmd = MNONE;
      else             cmd = 2'b11;
      sel = $urandom_range(0, 7);
      case (sel)
        4:       addr = 9'h100;
        5:       addr = 9'h120;
        6:       addr = 9'h140;
        7: begin
          addr = 9'h100 | 9'($urandom_range(0, 255));
          if (addr == 9'h100 || addr == 9'h120 || addr == 9'h140) addr = 9'h1FF;
        end
        default: addr = {1'b0, 8'($urandom_range(0, 255))};
      endcase
      wdata = 16'($urandom);
      model_access(cmd, addr, wdata, exp_lat);
      do_access(cmd, addr, wdata, lat, rd, ra);
      tests_run++;
      if (lat !== exp_lat || rd !== exp_rd || ra !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_access #%0d cmd=%b addr=%h: lat=%0d rd=%h after=%b, required %0d %h 0",
                 n, cmd, addr, lat, rd, ra, exp_lat, exp_rd);
      end
      tests_run++;
      if (led_out !== exp_led || hex_value !== exp_hex || bad_addr !== exp_bad) begin
        tests_failed++;
        $display("FAIL rand_regs #%0d: led=%h hex=%h bad=%b, required %h %h %b",
                 n, led_out, hex_value, bad_addr, exp_led, exp_hex, exp_bad);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_arr[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    exp_sw = 8'h00;
    model_reset();
    test_reset();
    test_ram();
    test_regs();
    test_switches();
    test_unmapped();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
